// File: rtl/shift_chain_reader_pkg.sv
// Shared types and constants for the shift-chain reader.
package shift_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    OUT,
    DONE,
    WAIT_CLEAR
  } state_t;

  localparam int DEF_TRIGGER_COUNT = 6;
  localparam int DEF_WORD_BITS     = 32;
  localparam int DEF_CLK_DIV       = 4;

  // Counter/index width that stays at least 1 bit for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_chain_reader_if.sv
// Word delivery handshake between the reader (master) and its consumer (slave).
interface shift_chain_reader_if #(
  parameter int WORD_BITS = 32,
  parameter int IDX_W     = 3
);
  logic [WORD_BITS-1:0] word_o;
  logic [IDX_W-1:0]     word_index_o;
  logic                 word_valid_o;
  logic                 word_ready_i;

  modport master (output word_o, word_index_o, word_valid_o, input word_ready_i);
  modport slave  (input word_o, word_index_o, word_valid_o, output word_ready_i);
endinterface

// File: rtl/shift_chain_reader_sync2.sv
// Two-flop synchronizer for asynchronous chain inputs, reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/shift_chain_reader.sv
// Host-side reader for the trigger-timer shift chain: generates DATA_CLK, samples
// DATA_OUT MSB first and hands out one word per stage. Optional abort: SHIFT_READER_ABORT_EN.
module shift_chain_reader
  import shift_reader_pkg::*;
#(
  parameter int TRIGGER_COUNT = DEF_TRIGGER_COUNT,
  parameter int WORD_BITS     = DEF_WORD_BITS,
  parameter int CLK_DIV       = DEF_CLK_DIV
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    DATA_READY,
  input  logic                    DATA_OUT,
  output logic                    DATA_CLK,
  shift_chain_reader_if.master    word_if,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    abort_o
);
  localparam int IDX_W = idx_width(TRIGGER_COUNT);
  localparam int BIT_W = idx_width(WORD_BITS);
  localparam int DIV_W = idx_width(CLK_DIV);

  logic rdy_s, dat_s;

  sync2 u_rdy_sync (.clk(CLK), .rst(RESET), .d(DATA_READY), .q(rdy_s));
  sync2 u_dat_sync (.clk(CLK), .rst(RESET), .d(DATA_OUT),   .q(dat_s));

  state_t               state;
  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [IDX_W-1:0]     idx;
  logic [WORD_BITS-1:0] sr;
  logic [WORD_BITS-1:0] word_q;
  logic                 valid_q;
  logic                 dclk_q;
  logic                 busy_q;
  logic                 done_q;

  wire div_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
  wire last_bit = (bit_cnt == BIT_W'(WORD_BITS - 1));
  wire last_idx = (idx == IDX_W'(TRIGGER_COUNT - 1));

`ifdef SHIFT_READER_ABORT_EN
  logic abort_q;
  // Losing the captured flag mid-read means the chain contents are no longer trustworthy.
  wire  abort_now = !rdy_s && (state == LOW || state == HIGH || state == OUT);
  assign abort_o = abort_q;
`else
  assign abort_o = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      idx     <= '0;
      sr      <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      dclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFT_READER_ABORT_EN
      abort_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SHIFT_READER_ABORT_EN
      abort_q <= 1'b0;
      if (abort_now) begin
        state   <= IDLE;
        div_cnt <= '0;
        bit_cnt <= '0;
        idx     <= '0;
        valid_q <= 1'b0;
        dclk_q  <= 1'b0;
        busy_q  <= 1'b0;
        abort_q <= 1'b1;
      end else
`endif
      begin
        case (state)
          IDLE: begin
            dclk_q <= 1'b0;
            if (rdy_s) begin
              state   <= LOW;
              div_cnt <= '0;
              busy_q  <= 1'b1;
            end
          end
          LOW: begin
            if (div_end) begin
              // Sample just before the rising edge that shifts the chain.
              sr      <= {sr[WORD_BITS-2:0], dat_s};
              div_cnt <= '0;
              dclk_q  <= 1'b1;
              state   <= HIGH;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          HIGH: begin
            if (div_end) begin
              div_cnt <= '0;
              dclk_q  <= 1'b0;
              if (last_bit) begin
                word_q  <= sr;
                bit_cnt <= '0;
                valid_q <= 1'b1;
                state   <= OUT;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                state   <= LOW;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          OUT: begin
            dclk_q <= 1'b0;
            if (word_if.word_ready_i) begin
              valid_q <= 1'b0;
              if (last_idx) begin
                done_q <= 1'b1;
                state  <= DONE;
              end else begin
                idx   <= idx + 1'b1;
                state <= LOW;
              end
            end
          end
          DONE: begin
            idx   <= '0;
            state <= WAIT_CLEAR;
          end
          WAIT_CLEAR: begin
            // Hold off until the flag drops so one capture is read only once.
            if (!rdy_s) begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
            dclk_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign DATA_CLK             = dclk_q;
  assign busy_o               = busy_q;
  assign done_o               = done_q;
  assign word_if.word_o       = word_q;
  assign word_if.word_index_o = idx;
  assign word_if.word_valid_o = valid_q;

endmodule

// File: tb/tb_shift_chain_reader.sv
// Directed bench for shift_chain_reader with a behavioural 6x32-bit shift chain model.
module tb_shift_chain_reader;
  localparam int TC = 6;
  localparam int WB = 32;
  localparam int CB = TC * WB;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic DATA_READY = 1'b0;
  logic DATA_OUT, DATA_CLK, busy_o, done_o, abort_o;

  shift_chain_reader_if #(.WORD_BITS(WB), .IDX_W(3)) wif ();

  shift_chain_reader #(.TRIGGER_COUNT(TC), .WORD_BITS(WB), .CLK_DIV(4)) dut (
    .CLK(CLK), .RESET(RESET), .DATA_READY(DATA_READY), .DATA_OUT(DATA_OUT),
    .DATA_CLK(DATA_CLK), .word_if(wif), .busy_o(busy_o), .done_o(done_o), .abort_o(abort_o)
  );

  always #5 CLK = ~CLK;

  // Chain model: stage 0 sits in the top word, shifts on DATA_CLK rise, fills with zeros.
  logic [CB-1:0] chain = '0;
  logic [CB-1:0] chain_init = '0;
  logic clr = 1'b0;
  logic prev_dclk = 1'b0;
  int edges = 0;
  int done_cnt = 0;

  assign DATA_OUT = chain[CB-1];

  always @(posedge CLK) begin
    prev_dclk <= DATA_CLK;
    if (clr) begin
      chain    <= chain_init;
      edges    <= 0;
      done_cnt <= 0;
    end else begin
      if (DATA_CLK && !prev_dclk) begin
        chain <= {chain[CB-2:0], 1'b0};
        edges <= edges + 1;
      end
      if (done_o) done_cnt <= done_cnt + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic preload(input logic [CB-1:0] v);
    chain_init = v;
    clr = 1'b1;
    @(negedge CLK);
    clr = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int k = 0;
    while (!wif.word_valid_o && k < max) begin
      @(negedge CLK);
      k++;
    end
    check(tag, {31'd0, wif.word_valid_o}, 32'd1);
  endtask

  task automatic get_word(input int idx, input logic [31:0] val, input int stall);
    wait_valid($sformatf("w%0d valid", idx), 2000);
    check($sformatf("w%0d index", idx), {29'd0, wif.word_index_o}, idx);
    check($sformatf("w%0d value", idx), wif.word_o, val);
    for (int s = 0; s < stall; s++) begin
      @(negedge CLK);
      check("stall dclk", {31'd0, DATA_CLK}, 32'd0);
      check("stall word", wif.word_o, val);
      check("stall valid", {31'd0, wif.word_valid_o}, 32'd1);
    end
    if (!wif.word_ready_i) begin
      wif.word_ready_i = 1'b1;
      @(negedge CLK);
      wif.word_ready_i = 1'b0;
    end else begin
      @(negedge CLK);
    end
    check($sformatf("w%0d valid drop", idx), {31'd0, wif.word_valid_o}, 32'd0);
  endtask

  logic [CB-1:0] w_seq;
  logic [CB-1:0] w_pat;

  initial begin
    w_seq = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    w_pat = {32'hA5A5_5A5A, 160'd0};
    wif.word_ready_i = 1'b0;
    RESET = 1'b1;
    cyc(3);
    check("rst dclk",  {31'd0, DATA_CLK}, 0);
    check("rst word",  wif.word_o, 0);
    check("rst index", {29'd0, wif.word_index_o}, 0);
    check("rst valid", {31'd0, wif.word_valid_o}, 0);
    check("rst busy",  {31'd0, busy_o}, 0);
    check("rst done",  {31'd0, done_o}, 0);
    check("rst abort", {31'd0, abort_o}, 0);
    RESET = 1'b0;
    cyc(2);

    // Full read, consumer always ready
    preload(w_seq);
    wif.word_ready_i = 1'b1;
    DATA_READY = 1'b1;
    for (int i = 0; i < TC; i++) get_word(i, 32'(i + 1), 0);
    check("t1 done pulse", {31'd0, done_o}, 1);
    cyc(1);
    check("t1 done single", {31'd0, done_o}, 0);
    check("t1 edges", edges, 192);
    check("t1 done count", done_cnt, 1);
    check("t1 chain empty", {31'd0, (chain == '0)}, 1);

    // Flag held after DONE: no re-read
    cyc(40);
    check("hold edges", edges, 192);
    check("hold busy", {31'd0, busy_o}, 1);
    check("hold valid", {31'd0, wif.word_valid_o}, 0);
    DATA_READY = 1'b0;
    cyc(4);
    check("clear busy", {31'd0, busy_o}, 0);

    // Re-raise: starts 3 cycles later; stall word 2 for 10 cycles
    wif.word_ready_i = 1'b0;
    preload(w_seq);
    DATA_READY = 1'b1;
    cyc(2);
    check("restart not yet", {31'd0, busy_o}, 0);
    cyc(1);
    check("restart busy", {31'd0, busy_o}, 1);
    for (int i = 0; i < TC; i++) get_word(i, 32'(i + 1), (i == 2) ? 10 : 0);
    check("t2 done pulse", {31'd0, done_o}, 1);
    cyc(1);
    check("t2 edges", edges, 192);
    check("t2 done count", done_cnt, 1);
    DATA_READY = 1'b0;
    cyc(4);

    // Reset mid-word 3
    preload(w_seq);
    wif.word_ready_i = 1'b1;
    DATA_READY = 1'b1;
    for (int i = 0; i < 3; i++) get_word(i, 32'(i + 1), 0);
    begin
      int k = 0;
      while (edges < 114 && k < 2000) begin
        @(negedge CLK);
        k++;
      end
    end
    check("t4 reached bit17", edges, 114);
    RESET = 1'b1;
    DATA_READY = 1'b0;
    wif.word_ready_i = 1'b0;
    cyc(1);
    check("t4 dclk",  {31'd0, DATA_CLK}, 0);
    check("t4 valid", {31'd0, wif.word_valid_o}, 0);
    check("t4 index", {29'd0, wif.word_index_o}, 0);
    check("t4 word",  wif.word_o, 0);
    check("t4 busy",  {31'd0, busy_o}, 0);
    check("t4 done",  {31'd0, done_o}, 0);
    check("t4 abort", {31'd0, abort_o}, 0);
    RESET = 1'b0;

    // Fresh read after reset, pattern word and first-valid latency
    preload(w_pat);
    DATA_READY = 1'b1;
    cyc(258);
    check("t5 valid at 258", {31'd0, wif.word_valid_o}, 0);
    cyc(1);
    check("t5 valid at 259", {31'd0, wif.word_valid_o}, 1);
    check("t5 word", wif.word_o, 32'hA5A5_5A5A);
    check("t5 index", {29'd0, wif.word_index_o}, 0);
    RESET = 1'b1;
    DATA_READY = 1'b0;
    cyc(2);
    RESET = 1'b0;
    cyc(2);

    // Flag dropped during word 1
    preload(w_seq);
    wif.word_ready_i = 1'b1;
    DATA_READY = 1'b1;
    get_word(0, 32'd1, 0);
    begin
      int k = 0;
      while (edges < 40 && k < 2000) begin
        @(negedge CLK);
        k++;
      end
    end
    check("t6 in word1", {31'd0, (edges >= 40)}, 1);
    DATA_READY = 1'b0;
`ifdef SHIFT_READER_ABORT_EN
    begin
      int k = 0;
      while (!abort_o && k < 10) begin
        @(negedge CLK);
        k++;
      end
    end
    check("t6 abort pulse", {31'd0, abort_o}, 1);
    check("t6 abort dclk", {31'd0, DATA_CLK}, 0);
    cyc(1);
    check("t6 abort single", {31'd0, abort_o}, 0);
    check("t6 idle", {31'd0, busy_o}, 0);
    check("t6 valid", {31'd0, wif.word_valid_o}, 0);
    cyc(400);
    check("t6 no done", done_cnt, 0);
    check("t6 still idle", {31'd0, busy_o}, 0);
`else
    for (int i = 1; i < TC; i++) get_word(i, 32'(i + 1), 0);
    check("t6 done pulse", {31'd0, done_o}, 1);
    cyc(1);
    check("t6 done count", done_cnt, 1);
    check("t6 edges", edges, 192);
    cyc(3);
    check("t6 idle", {31'd0, busy_o}, 0);
    check("t6 abort", {31'd0, abort_o}, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
